// File: rtl/flash_read_ctrl.sv
// flash_read_ctrl: Wishbone-programmable read sequencer for the 8x8 flash array.
// Firmware sets the phase timings and starts a read. The block drives sen1, sen2 and
// out_en through PRECHARGE -> SENSE -> CAPTURE, then captures the synchronized sensed byte.

module flash_read_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [7:0]  RST_TPRE   = 8'd4,
    parameter logic [7:0]  RST_TSENSE = 8'd8,
    parameter logic [7:0]  RST_TCAP   = 8'd4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [7:0]  sense_data,
    output logic        sen1,
    output logic        sen2,
    output logic [3:0]  out_en,
    output logic        irq
);

    localparam logic [3:0] OffCtrl   = 4'h0;
    localparam logic [3:0] OffTiming = 4'h4;
    localparam logic [3:0] OffData   = 4'h8;
    localparam logic [3:0] OffStatus = 4'hC;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StSense,
        StCap
    } state_e;

    // A programmed length of 0 still occupies one cycle.
    function automatic logic [7:0] eff_len(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic        ack_q;
    logic [31:0] dat_q;
    logic        win_hit;
    logic        req;
    logic        wr_req;
    logic [3:0]  offset;
    logic        wr_ctrl;
    logic        wr_timing;
    logic        wr_status;
    logic [31:0] rdata;

    assign win_hit   = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // A new request is only taken while ack is low, so back-to-back requests
    // are acknowledged every other cycle.
    assign req       = wbs_stb_i & wbs_cyc_i & win_hit & ~ack_q;
    assign wr_req    = req & wbs_we_i;
    assign offset    = wbs_adr_i[3:0];
    assign wr_ctrl   = wr_req && (offset == OffCtrl) && wbs_sel_i[0];
    assign wr_timing = wr_req && (offset == OffTiming);
    assign wr_status = wr_req && (offset == OffStatus) && wbs_sel_i[0];

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic       start_q;
    logic       abort_q;
    logic       irq_en_q;
    logic [3:0] oen_mask_q;
    logic [7:0] t_pre_q;
    logic [7:0] t_sense_q;
    logic [7:0] t_cap_q;
    logic [7:0] data_q;
    logic       done_q;
    logic       done_d;
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    state_e     state_q;
    state_e     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] lat_sense_q;
    logic [7:0] lat_cap_q;
    logic [3:0] lat_oen_q;
    logic       latch;
    logic       capture;
    logic       busy;

    assign busy = (state_q != StIdle);

    // Read data mux; unmapped offsets read as zero.
    always_comb begin
        rdata = 32'h0;
        unique case (offset)
            OffCtrl:   rdata = {24'h0, oen_mask_q, 1'b0, irq_en_q, 2'b00};
            OffTiming: rdata = {8'h0, t_cap_q, t_sense_q, t_pre_q};
            OffData:   rdata = {24'h0, data_q};
            OffStatus: rdata = {30'h0, done_q, busy};
            default:   rdata = 32'h0;
        endcase
    end

    // Wishbone handshake: ack and read data one cycle after the request.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
        end else begin
            ack_q <= req;
            dat_q <= (req && !wbs_we_i) ? rdata : 32'h0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    // CTRL register: start/abort are single-cycle pulses, the rest is stored.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            irq_en_q   <= 1'b0;
            oen_mask_q <= 4'h0;
        end else begin
            start_q <= wr_ctrl & wbs_dat_i[0];
            abort_q <= wr_ctrl & wbs_dat_i[1];
            if (wr_ctrl) begin
                irq_en_q   <= wbs_dat_i[2];
                oen_mask_q <= wbs_dat_i[7:4];
            end
        end
    end

    // TIMING register with per-byte write enables.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            t_pre_q   <= RST_TPRE;
            t_sense_q <= RST_TSENSE;
            t_cap_q   <= RST_TCAP;
        end else if (wr_timing) begin
            if (wbs_sel_i[0]) t_pre_q   <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) t_sense_q <= wbs_dat_i[15:8];
            if (wbs_sel_i[2]) t_cap_q   <= wbs_dat_i[23:16];
        end
    end

    // Two-flop synchronizer for the asynchronous array output.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= 8'h0;
            sync2_q <= 8'h0;
        end else begin
            sync1_q <= sense_data;
            sync2_q <= sync1_q;
        end
    end

    // done: set by capture, cleared by W1C; set wins on collision.
    always_comb begin
        done_d = done_q;
        if (wr_status && wbs_dat_i[1]) done_d = 1'b0;
        if (capture) done_d = 1'b1;
    end

    // Captured byte and sticky done flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            data_q <= 8'h0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (capture) data_q <= sync2_q;
        end
    end

    assign irq = done_q & irq_en_q;

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------

    // Next-state, phase counter and sense-control outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        capture = 1'b0;
        sen1    = 1'b0;
        sen2    = 1'b0;
        out_en  = 4'h0;
        unique case (state_q)
            StIdle: begin
                if (start_q && !abort_q) begin
                    state_d = StPre;
                    cnt_d   = eff_len(t_pre_q);
                    latch   = 1'b1;
                end
            end
            StPre: begin
                sen1 = 1'b1;
                if (cnt_q <= 8'd1) begin
                    state_d = StSense;
                    cnt_d   = eff_len(lat_sense_q);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StSense: begin
                sen1 = 1'b1;
                sen2 = 1'b1;
                if (cnt_q <= 8'd1) begin
                    state_d = StCap;
                    cnt_d   = eff_len(lat_cap_q);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCap: begin
                sen1   = 1'b1;
                sen2   = 1'b1;
                out_en = lat_oen_q;
                if (cnt_q <= 8'd1) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
        // Abort overrides everything, including a capture on the final cycle.
        if (abort_q) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
            latch   = 1'b0;
            capture = 1'b0;
        end
    end

    // Sequencer state, phase counter and the settings frozen at start.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            lat_sense_q <= 8'd0;
            lat_cap_q   <= 8'd0;
            lat_oen_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                lat_sense_q <= t_sense_q;
                lat_cap_q   <= t_cap_q;
                lat_oen_q   <= oen_mask_q;
            end
        end
    end

    // Bus bits with no register behind them.
    logic unused_bits;
    assign unused_bits = ^{wbs_dat_i[31:24], wbs_sel_i[3], wbs_dat_i[3]};

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Self-checking bench for flash_read_ctrl: register table, hand-written corner
// sequences and randomized reads against a cycle-arithmetic reference model.

module tb_flash_read_ctrl;

    localparam logic [31:0] Base = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  sense = 8'h0;
    logic        sen1;
    logic        sen2;
    logic [3:0]  out_en;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flash_read_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .sense_data (sense),
        .sen1       (sen1),
        .sen2       (sen2),
        .out_en     (out_en),
        .irq        (irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        exp_ack;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] b, input logic ea, input logic [31:0] er);
        vec_t v;
        v.addr = a; v.wr = w; v.data = d; v.be = b; v.exp_ack = ea; v.exp_rd = er;
        vecs.push_back(v);
    endtask

    // One bus transfer; gives up after 4 cycles without ack.
    task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] b, output logic acked, output logic [31:0] rd);
        acked = 1'b0;
        rd    = 32'h0;
        adr = a; we = w; wdat = d; sel = b; stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rd    = rdat;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input string name, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
        logic        acked;
        logic [31:0] rd;
        wb_access(a, 1'b1, d, b, acked, rd);
        check({name, "_ack"}, {31'h0, acked}, 32'h1);
    endtask

    task automatic wb_read_check(input string name, input logic [31:0] a,
                                 input logic [31:0] exp);
        logic        acked;
        logic [31:0] rd;
        wb_access(a, 1'b0, 32'h0, 4'hF, acked, rd);
        check({name, "_ack"}, {31'h0, acked}, 32'h1);
        check(name, rd, exp);
    endtask

    // Reference model: the expected pins in cycle k after the start write's ack
    // cycle follow from the three effective phase lengths alone.
    function automatic logic [6:0] model_pins(input int k, input int p, input int s,
                                              input int c, input logic [3:0] mask,
                                              input logic ie);
        if (k <= p)              return {1'b0, 1'b1, 1'b0, 4'h0};
        else if (k <= p + s)     return {1'b0, 1'b1, 1'b1, 4'h0};
        else if (k <= p + s + c) return {1'b0, 1'b1, 1'b1, mask};
        else                     return {ie, 1'b0, 1'b0, 4'h0};
    endfunction

    // Call directly after the start write returns (ack cycle).
    task automatic run_read_check(input string tag, input logic [7:0] tp, input logic [7:0] ts,
                                  input logic [7:0] tc, input logic [3:0] mask,
                                  input logic ie);
        int p, s, c;
        logic [6:0] exp;
        p = (tp == 8'd0) ? 1 : int'(tp);
        s = (ts == 8'd0) ? 1 : int'(ts);
        c = (tc == 8'd0) ? 1 : int'(tc);
        for (int k = 1; k <= p + s + c + 1; k++) begin
            @(posedge clk); #1;
            exp = model_pins(k, p, s, c, mask, ie);
            check($sformatf("%s_cyc%0d", tag, k), {25'h0, irq, sen1, sen2, out_en},
                  {25'h0, exp});
        end
    endtask

    logic [23:0] timing_m;

    initial begin
        logic        acked;
        logic [31:0] rd;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_pins", {25'h0, ack, irq, sen1, sen2, out_en}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Register table
        add_vec(Base + 32'h4, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0004_0804);
        add_vec(Base + 32'hC, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0);
        add_vec(Base + 32'h0, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0);
        add_vec(Base + 32'h8, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0);
        add_vec(Base + 32'h4, 1'b1, 32'hFFFF_FFFF, 4'b0010, 1'b1, 32'h0);
        add_vec(Base + 32'h4, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0004_FF04);
        add_vec(Base + 32'h10, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0);
        add_vec(Base + 32'h10, 1'b1, 32'h0000_0000, 4'hF, 1'b0, 32'h0);
        add_vec(Base + 32'h4, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0004_FF04);
        add_vec(Base + 32'h0, 1'b1, 32'hFFFF_FFF4, 4'b0001, 1'b1, 32'h0);
        add_vec(Base + 32'h0, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0000_00F4);
        add_vec(Base + 32'h0, 1'b1, 32'h0000_0001, 4'b0000, 1'b1, 32'h0);
        add_vec(Base + 32'hC, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0);
        add_vec(Base + 32'h0, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0000_00F4);
        add_vec(Base + 32'h4, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 32'h0);
        add_vec(Base + 32'h4, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0034_5678);
        add_vec(Base + 32'h4, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b1, 32'h0);
        add_vec(Base + 32'h4, 1'b0, 32'h0, 4'hF, 1'b1, 32'h00BB_56DD);
        add_vec(32'h2FFF_FFFC, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0);
        add_vec(Base + 32'h4, 1'b1, 32'h0004_0804, 4'hF, 1'b1, 32'h0);
        add_vec(Base + 32'h0, 1'b1, 32'h0, 4'hF, 1'b1, 32'h0);
        add_vec(Base + 32'h0, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0);
        foreach (vecs[i]) begin
            wb_access(vecs[i].addr, vecs[i].wr, vecs[i].data, vecs[i].be, acked, rd);
            check($sformatf("vec%0d_ack", i), {31'h0, acked}, {31'h0, vecs[i].exp_ack});
            if (vecs[i].exp_ack && !vecs[i].wr)
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            @(posedge clk); #1;
            check($sformatf("vec%0d_ack_drop", i), {31'h0, ack}, 32'h0);
        end

        // Default read
        sense = 8'hA5;
        wb_write("def_start", Base, 32'h0000_00F5, 4'hF);
        run_read_check("def", 8'd4, 8'd8, 8'd4, 4'hF, 1'b1);
        wb_read_check("def_data", Base + 32'h8, 32'h0000_00A5);
        wb_read_check("def_status", Base + 32'hC, 32'h2);
        wb_write("def_w1c", Base + 32'hC, 32'h2, 4'hF);
        check("def_irq_clr", {31'h0, irq}, 32'h0);
        wb_read_check("def_status_clr", Base + 32'hC, 32'h0);

        // Zero timing: every phase one cycle
        wb_write("zero_timing", Base + 32'h4, 32'h0, 4'hF);
        sense = 8'h5A;
        wb_write("zero_start", Base, 32'h0000_0035, 4'hF);
        run_read_check("zero", 8'd0, 8'd0, 8'd0, 4'h3, 1'b1);
        wb_read_check("zero_data", Base + 32'h8, 32'h0000_005A);
        wb_write("zero_w1c", Base + 32'hC, 32'h2, 4'hF);

        // Abort mid-SENSE
        wb_write("abort_timing", Base + 32'h4, 32'h0004_0804, 4'hF);
        sense = 8'h3C;
        wb_write("abort_start", Base, 32'h0000_00F5, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        check("abort_in_sense", {29'h0, sen1, sen2, irq}, 32'h6);
        wb_write("abort_wr", Base, 32'h0000_00F6, 4'hF);
        @(posedge clk); #1;
        check("abort_pins", {25'h0, irq, sen1, sen2, out_en}, 32'h0);
        wb_read_check("abort_status", Base + 32'hC, 32'h0);
        wb_read_check("abort_data", Base + 32'h8, 32'h0000_005A);

        // Start while busy is ignored
        sense = 8'h96;
        wb_write("busy_start", Base, 32'h0000_00F5, 4'hF);
        fork
            run_read_check("busy", 8'd4, 8'd8, 8'd4, 4'hF, 1'b1);
            begin
                @(posedge clk); #1;
                wb_write("busy_restart", Base, 32'h0000_00F5, 4'hF);
            end
        join
        wb_read_check("busy_data", Base + 32'h8, 32'h0000_0096);
        wb_write("busy_w1c", Base + 32'hC, 32'h2, 4'hF);
        repeat (12) @(posedge clk);
        #1;
        wb_read_check("busy_single", Base + 32'hC, 32'h0);

        // Reset mid-read
        wb_write("rstmid_timing", Base + 32'h4, 32'h0003_0303, 4'hF);
        wb_write("rstmid_start", Base, 32'h0000_00F5, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_pins", {25'h0, irq, sen1, sen2, out_en}, 32'h0);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        wb_read_check("rstmid_timing_rd", Base + 32'h4, 32'h0004_0804);
        wb_read_check("rstmid_data", Base + 32'h8, 32'h0);
        wb_read_check("rstmid_status", Base + 32'hC, 32'h0);

        // Randomized reads
        timing_m = 24'h04_08_04;
        for (int it = 0; it < 10; it++) begin
            logic [31:0] d;
            logic [3:0]  b;
            logic [3:0]  mask;
            logic        ie;
            for (int j = 0; j < 3; j++)
                d[j*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40))
                                                          : 8'($urandom_range(0, 5));
            d[31:24] = 8'($urandom);
            b = 4'($urandom_range(0, 15));
            for (int j = 0; j < 3; j++)
                if (b[j]) timing_m[j*8 +: 8] = d[j*8 +: 8];
            wb_write($sformatf("rnd%0d_timing", it), Base + 32'h4, d, b);
            wb_read_check($sformatf("rnd%0d_timing_rd", it), Base + 32'h4, {8'h0, timing_m});
            sense = 8'($urandom);
            mask  = 4'($urandom);
            ie    = 1'($urandom);
            wb_write($sformatf("rnd%0d_start", it), Base,
                     {24'($urandom), mask, 1'b0, ie, 2'b01}, 4'b0001);
            run_read_check($sformatf("rnd%0d", it), timing_m[7:0], timing_m[15:8],
                           timing_m[23:16], mask, ie);
            wb_read_check($sformatf("rnd%0d_data", it), Base + 32'h8, {24'h0, sense});
            wb_read_check($sformatf("rnd%0d_status", it), Base + 32'hC, 32'h2);
            wb_write($sformatf("rnd%0d_w1c", it), Base + 32'hC, 32'h2, 4'hF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flash_read_ctrl.md
# flash_read_ctrl

Digital read sequencer that drives the sense-control side of the 8x8 flash array and captures its 8-bit sensed output. Sits in the user project wrapper as a Wishbone slave: firmware programs phase timings, starts a read, and collects the captured byte; the block generates `sen1`, `sen2` and `out_en` in the correct order and samples the array's `out` bus.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: Wishbone base; block decodes `wbs_adr_i[31:4] == BASE_ADDR[31:4]`.
- `RST_TPRE`, default 4: reset value of precharge phase length (cycles).
- `RST_TSENSE`, default 8: reset value of sense phase length (cycles).
- `RST_TCAP`, default 4: reset value of capture phase length (cycles).

- `wb_clk_i  in  1  sole clock; all logic on rising edge`
- `wb_rst_i  in  1  synchronous, active-high reset`
- `wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe/cycle/write`
- `wbs_sel_i  in  4  byte enables (writes)`
- `wbs_adr_i  in  32  byte address`
- `wbs_dat_i  in  32  write data`
- `wbs_ack_o  out  1  transfer acknowledge`
- `wbs_dat_o  out  32  read data`
- `sense_data  in  8  array sensed output (asynchronous to clock)`
- `sen1  out  1  sense enable 1 (precharge)`
- `sen2  out  1  sense enable 2 (evaluate)`
- `out_en  out  4  array output-driver group enables`
- `irq  out  1  level interrupt: done & irq_en`

## Operation
- Registers (offset): 0x0 CTRL: [0] start (write-1 pulse, reads 0), [1] abort (write-1 pulse, reads 0), [2] irq_en, [7:4] oen_mask. 0x4 TIMING: [7:0] t_pre, [15:8] t_sense, [23:16] t_cap. 0x8 DATA: [7:0] last captured byte, read-only. 0xC STATUS: [0] busy (RO), [1] done (sticky, write-1-to-clear).
- CTRL/TIMING writes honour `wbs_sel_i` per byte. Unmapped offsets inside the 16-byte window: write ignored, read 0. Addresses outside window: no ack.
- `sense_data` passes a 2-flop synchronizer before use.
- FSM states and outputs:
  - IDLE: sen1=0, sen2=0, out_en=0, busy=0. start=1 -> PRECHARGE.
  - PRECHARGE: sen1=1; stays max(t_pre,1) cycles -> SENSE.
  - SENSE: sen1=1, sen2=1; stays max(t_sense,1) cycles -> CAPTURE.
  - CAPTURE: sen1=1, sen2=1, out_en=oen_mask (latched at start); stays max(t_cap,1) cycles; on last cycle DATA <= synchronized sense_data, done <= 1 -> IDLE.
- Phase counter 8-bit down-counter loaded with the effective length on state entry; no wrap (0 treated as 1).
- start while busy: ignored. TIMING/oen_mask writes while busy: register updates, but running read uses values latched at start.
- abort (any state): next cycle IDLE, all outputs low, DATA and done unchanged. abort and start in the same write: abort wins, stays IDLE.
- done set and W1C clear in same cycle: set wins.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, sen1=0, sen2=0, out_en=0, irq=0; CTRL=0, TIMING={RST_TCAP,RST_TSENSE,RST_TPRE}, DATA=0, done=0, FSM=IDLE.
- Wishbone: ack asserted one cycle after stb&cyc seen with ack low; ack high exactly one cycle; read data valid with ack. Back-to-back requests get ack every other cycle.
- Start: write acked in cycle N; sen1 rises at N+1 (FSM in PRECHARGE).
- Total read latency from sen1 rise to done = t_pre + t_sense + t_cap cycles; irq rises same cycle as done.
- Captured value reflects `sense_data` ≥2 cycles before the last CAPTURE cycle; firmware keeps t_cap ≥ 3 for a settled sample.
- Reset mid-read: next edge returns everything to reset values; no capture.

## Test plan
- Reset: assert wb_rst_i 2 cycles -> all outputs 0, TIMING reads 0x00_04_08_04 with defaults, STATUS reads 0.
- Default read: sense_data=0xA5, write CTRL=0xF5 (start, irq_en, mask 0xF) -> sen1 high 4 cycles alone, then sen1&sen2 8 cycles, out_en=0xF for 4 cycles; DATA=0xA5, STATUS=0x2, irq=1; W1C STATUS bit1 -> irq=0.
- Zero timing: TIMING=0 then start -> each phase exactly 1 cycle, done 3 cycles after sen1 rise.
- Abort mid-SENSE: start, write CTRL bit1 during SENSE -> outputs low next cycle, busy=0, done stays 0, DATA keeps prior value.
- Start while busy: second start during PRECHARGE -> ignored, single read of expected length, one done.
- Byte-enable write: TIMING write 0xFFFFFFFF with sel=0b0010 -> TIMING reads 0x00_04_FF_04; access to offset 0x10 beyond window -> no ack.
